// File: rtl/cprv_pkg.sv
// Shared types and default widths for the CPU memory arbiter.
package cprv_pkg;

    localparam int unsigned CPRV_DATA_WIDTH = 64;
    localparam int unsigned CPRV_ADDR_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        IMEM = 1'b0,
        DMEM = 1'b1
    } owner_t;

    // One-hot grant encoding: bit 0 instruction port, bit 1 data port.
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IMEM = 2'b01;
    localparam logic [1:0] GNT_DMEM = 2'b10;

endpackage

// File: rtl/cprv_rr_arb2.sv
// Two-way round-robin grant; on a tie the port not granted last wins.
module cprv_rr_arb2
    import cprv_pkg::*;
(
    input  logic       i_valid_i,
    input  logic       d_valid_i,
    input  owner_t     last_owner_i,
    output logic [1:0] grant_c_o
);

    always_comb begin
        grant_c_o = GNT_NONE;
        if (i_valid_i && d_valid_i) begin
            grant_c_o = (last_owner_i == IMEM) ? GNT_DMEM : GNT_IMEM;
        end else if (i_valid_i) begin
            grant_c_o = GNT_IMEM;
        end else if (d_valid_i) begin
            grant_c_o = GNT_DMEM;
        end
    end

endmodule

// File: rtl/cprv_mem_arbiter.sv
// Shares one memory port between instruction fetch and data access,
// one outstanding transaction at a time.
module cprv_mem_arbiter
    import cprv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CPRV_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = CPRV_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_req_valid_i,
    output logic                  i_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] i_req_addr_i,
    output logic                  i_rsp_valid_o,
    input  logic                  i_rsp_ready_i,
    output logic [DATA_WIDTH-1:0] i_rsp_data_o,

    input  logic                  d_req_valid_i,
    output logic                  d_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] d_req_addr_i,
    input  logic [DATA_WIDTH-1:0] d_req_wdata_i,
    input  logic                  d_req_w_en_i,
    output logic                  d_rsp_valid_o,
    input  logic                  d_rsp_ready_i,
    output logic [DATA_WIDTH-1:0] d_rsp_data_o,

    output logic                  m_req_valid_o,
    input  logic                  m_req_ready_i,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    output logic [DATA_WIDTH-1:0] m_wdata_o,
    output logic                  m_w_en_o,
    input  logic                  m_rsp_valid_i,
    output logic                  m_rsp_ready_o,
    input  logic [DATA_WIDTH-1:0] m_rdata_i
);

    arb_state_t            state_q, state_d;
    owner_t                owner_q, owner_d;
    owner_t                last_owner_q, last_owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  w_en_q, w_en_d;
    logic [1:0]            grant_c;
    logic                  i_hs_c, d_hs_c, own_rsp_ready_c;

    cprv_rr_arb2 u_rr_arb2 (
        .i_valid_i    (i_req_valid_i),
        .d_valid_i    (d_req_valid_i),
        .last_owner_i (last_owner_q),
        .grant_c_o    (grant_c)
    );

    // Ready is gated by reset so nothing is accepted while rst_n is low.
    assign i_hs_c          = (state_q == IDLE) && rst_n && i_req_valid_i && grant_c[0];
    assign d_hs_c          = (state_q == IDLE) && rst_n && d_req_valid_i && grant_c[1];
    assign own_rsp_ready_c = (owner_q == DMEM) ? d_rsp_ready_i : i_rsp_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= IMEM;
            last_owner_q <= IMEM;
            addr_q       <= '0;
            wdata_q      <= '0;
            w_en_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            w_en_q       <= w_en_d;
        end
    end

    // Next state and handshake outputs; latched fields only move in IDLE.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        w_en_d        = w_en_q;
        i_req_ready_o = 1'b0;
        d_req_ready_o = 1'b0;
        m_req_valid_o = 1'b0;
        m_rsp_ready_o = 1'b0;
        i_rsp_valid_o = 1'b0;
        d_rsp_valid_o = 1'b0;
        i_rsp_data_o  = '0;
        d_rsp_data_o  = '0;

        unique case (state_q)
            IDLE: begin
                i_req_ready_o = rst_n && grant_c[0];
                d_req_ready_o = rst_n && grant_c[1];
                if (i_hs_c) begin
                    owner_d      = IMEM;
                    last_owner_d = IMEM;
                    addr_d       = i_req_addr_i;
                    wdata_d      = '0;
                    w_en_d       = 1'b0;
                    state_d      = REQ;
                end else if (d_hs_c) begin
                    owner_d      = DMEM;
                    last_owner_d = DMEM;
                    addr_d       = d_req_addr_i;
                    wdata_d      = d_req_wdata_i;
                    w_en_d       = d_req_w_en_i;
                    state_d      = REQ;
                end
            end
            REQ: begin
                m_req_valid_o = 1'b1;
                if (m_req_ready_i) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                m_rsp_ready_o = own_rsp_ready_c;
                if (owner_q == DMEM) begin
                    d_rsp_valid_o = m_rsp_valid_i;
                    d_rsp_data_o  = m_rdata_i;
                end else begin
                    i_rsp_valid_o = m_rsp_valid_i;
                    i_rsp_data_o  = m_rdata_i;
                end
                if (m_rsp_valid_i && own_rsp_ready_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_addr_o  = addr_q;
    assign m_wdata_o = wdata_q;
    assign m_w_en_o  = w_en_q;

endmodule

// File: tb/tb_cprv_mem_arbiter.sv
// Bench for cprv_mem_arbiter: directed table, hand-written corner sequences
// and a randomized run against a transaction-level reference model.
module tb_cprv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid_i, i_req_ready_o, i_rsp_valid_o, i_rsp_ready_i;
    logic [63:0] i_req_addr_i, i_rsp_data_o;
    logic        d_req_valid_i, d_req_ready_o, d_req_w_en_i, d_rsp_valid_o, d_rsp_ready_i;
    logic [63:0] d_req_addr_i, d_req_wdata_i, d_rsp_data_o;
    logic        m_req_valid_o, m_req_ready_i, m_w_en_o, m_rsp_valid_i, m_rsp_ready_o;
    logic [63:0] m_addr_o, m_wdata_o, m_rdata_i;

    always #5 clk = ~clk;

    cprv_mem_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_valid_i (i_req_valid_i),
        .i_req_ready_o (i_req_ready_o),
        .i_req_addr_i  (i_req_addr_i),
        .i_rsp_valid_o (i_rsp_valid_o),
        .i_rsp_ready_i (i_rsp_ready_i),
        .i_rsp_data_o  (i_rsp_data_o),
        .d_req_valid_i (d_req_valid_i),
        .d_req_ready_o (d_req_ready_o),
        .d_req_addr_i  (d_req_addr_i),
        .d_req_wdata_i (d_req_wdata_i),
        .d_req_w_en_i  (d_req_w_en_i),
        .d_rsp_valid_o (d_rsp_valid_o),
        .d_rsp_ready_i (d_rsp_ready_i),
        .d_rsp_data_o  (d_rsp_data_o),
        .m_req_valid_o (m_req_valid_o),
        .m_req_ready_i (m_req_ready_i),
        .m_addr_o      (m_addr_o),
        .m_wdata_o     (m_wdata_o),
        .m_w_en_o      (m_w_en_o),
        .m_rsp_valid_i (m_rsp_valid_i),
        .m_rsp_ready_o (m_rsp_ready_o),
        .m_rdata_i     (m_rdata_i)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: one outstanding transaction, its owner and payload.
    logic        busy, sent, cur_d, cur_wen, last_d;
    logic [63:0] cur_addr, cur_wdata, exp_data;
    logic [63:0] ref_mem   [logic [63:0]];
    // Memory responder storage, kept apart from the model's view.
    logic [63:0] mem_store [logic [63:0]];
    logic        mem_has, real_v;
    int          mem_delay;
    logic [63:0] mem_rdata;
    // Requester agents.
    logic        i_pend, d_pend, d_wen_p;
    logic [63:0] i_addr_p, d_addr_p, d_wdata_p;
    // Knobs and logs.
    int          p_mem_ready, p_rsp_ready, p_stray, max_delay;
    logic        gen_en;
    logic        grant_log [$];
    logic [63:0] i_rsp_log [$];
    logic [63:0] d_rsp_log [$];

    typedef struct {
        logic        iv, dv;
        logic [63:0] ia, da, dw;
        logic        dwe;
        logic        exp_first_d;
        logic [63:0] exp_i, exp_d;
    } row_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic pct(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    function automatic logic [63:0] dflt(input logic [63:0] a);
        return a ^ 64'h5A5A_0000_0000_0000;
    endfunction

    function automatic logic [63:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        return mem_store.exists(a) ? mem_store[a] : dflt(a);
    endfunction

    task automatic chk_all_zero();
        chk("rst_i_req_ready", 64'(i_req_ready_o), 64'd0);
        chk("rst_d_req_ready", 64'(d_req_ready_o), 64'd0);
        chk("rst_m_req_valid", 64'(m_req_valid_o), 64'd0);
        chk("rst_m_addr",      m_addr_o,            64'd0);
        chk("rst_m_wdata",     m_wdata_o,           64'd0);
        chk("rst_m_w_en",      64'(m_w_en_o),      64'd0);
        chk("rst_i_rsp_valid", 64'(i_rsp_valid_o), 64'd0);
        chk("rst_d_rsp_valid", 64'(d_rsp_valid_o), 64'd0);
        chk("rst_m_rsp_ready", 64'(m_rsp_ready_o), 64'd0);
    endtask

    // Reset with both requests raised to confirm ready is held low.
    task automatic do_reset();
        rst_n = 1'b0;
        i_req_valid_i = 1'b1; i_req_addr_i = 64'h0; i_rsp_ready_i = 1'b0;
        d_req_valid_i = 1'b1; d_req_addr_i = 64'h0; d_req_wdata_i = 64'h0;
        d_req_w_en_i = 1'b0; d_rsp_ready_i = 1'b0;
        m_req_ready_i = 1'b0; m_rsp_valid_i = 1'b0; m_rdata_i = 64'h0;
        #2;
        chk_all_zero();
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_req_valid_i = 1'b0;
        d_req_valid_i = 1'b0;
        rst_n = 1'b1;
        busy = 1'b0; sent = 1'b0; cur_d = 1'b0; cur_wen = 1'b0; last_d = 1'b0;
        cur_addr = '0; cur_wdata = '0; exp_data = '0;
        mem_has = 1'b0; real_v = 1'b0; mem_delay = 0; mem_rdata = '0;
        i_pend = 1'b0; d_pend = 1'b0;
    endtask

    // One clock: check outputs against the model, then advance everything.
    task automatic step();
        logic e_ir, e_dr, e_mv, in_rsp, own_rdy, e_rhs, mrdy;
        logic a_i, a_d, a_m, a_r;
        logic [63:0] ma, mw, ia, da, dw;
        logic mwe, dwe;
        @(negedge clk);
        e_ir    = !busy && i_req_valid_i && (!d_req_valid_i || last_d);
        e_dr    = !busy && d_req_valid_i && (!i_req_valid_i || !last_d);
        e_mv    = busy && !sent;
        in_rsp  = busy && sent;
        own_rdy = cur_d ? d_rsp_ready_i : i_rsp_ready_i;
        e_rhs   = in_rsp && m_rsp_valid_i && own_rdy;
        chk("i_req_ready", 64'(i_req_ready_o), 64'(e_ir));
        chk("d_req_ready", 64'(d_req_ready_o), 64'(e_dr));
        chk("m_req_valid", 64'(m_req_valid_o), 64'(e_mv));
        if (e_mv) begin
            chk("m_addr",  m_addr_o,        cur_addr);
            chk("m_wdata", m_wdata_o,       cur_wdata);
            chk("m_w_en",  64'(m_w_en_o),  64'(cur_wen));
        end
        chk("i_rsp_valid", 64'(i_rsp_valid_o), 64'(in_rsp && !cur_d && m_rsp_valid_i));
        chk("d_rsp_valid", 64'(d_rsp_valid_o), 64'(in_rsp && cur_d && m_rsp_valid_i));
        chk("m_rsp_ready", 64'(m_rsp_ready_o), 64'(in_rsp && own_rdy));
        if (e_rhs && !cur_wen)
            chk(cur_d ? "d_rsp_data" : "i_rsp_data", cur_d ? d_rsp_data_o : i_rsp_data_o, exp_data);
        a_i = i_req_valid_i && i_req_ready_o;
        a_d = d_req_valid_i && d_req_ready_o;
        a_m = m_req_valid_o && m_req_ready_i;
        a_r = m_rsp_valid_i && m_rsp_ready_o;
        if (a_i) grant_log.push_back(1'b0);
        if (a_d) grant_log.push_back(1'b1);
        if (i_rsp_valid_o && i_rsp_ready_i) i_rsp_log.push_back(i_rsp_data_o);
        if (d_rsp_valid_o && d_rsp_ready_i) d_rsp_log.push_back(d_rsp_data_o);
        ma = m_addr_o; mw = m_wdata_o; mwe = m_w_en_o; mrdy = m_req_ready_i;
        ia = i_req_addr_i; da = d_req_addr_i; dw = d_req_wdata_i; dwe = d_req_w_en_i;
        @(posedge clk); #1;
        if (e_ir || e_dr) begin
            busy = 1'b1; sent = 1'b0; cur_d = e_dr; last_d = e_dr;
            cur_addr  = e_dr ? da : ia;
            cur_wdata = e_dr ? dw : 64'h0;
            cur_wen   = e_dr && dwe;
            if (cur_wen) ref_mem[cur_addr] = cur_wdata;
            exp_data = ref_rd(cur_addr);
        end else if (e_mv && mrdy) begin
            sent = 1'b1;
        end else if (e_rhs) begin
            busy = 1'b0;
        end
        if (a_i) i_pend = 1'b0;
        if (a_d) d_pend = 1'b0;
        if (gen_en && !i_pend && pct(40)) begin
            i_pend = 1'b1;
            i_addr_p = 64'h3000 + 64'($urandom_range(7)) * 64'd8;
        end
        if (gen_en && !d_pend && pct(40)) begin
            d_pend = 1'b1;
            d_addr_p = 64'h3000 + 64'($urandom_range(7)) * 64'd8;
            d_wdata_p = {$urandom, $urandom};
            d_wen_p = pct(40);
        end
        i_req_valid_i = i_pend; i_req_addr_i = i_addr_p;
        d_req_valid_i = d_pend; d_req_addr_i = d_addr_p;
        d_req_wdata_i = d_wdata_p; d_req_w_en_i = d_wen_p;
        i_rsp_ready_i = pct(p_rsp_ready);
        d_rsp_ready_i = pct(p_rsp_ready);
        if (a_r && real_v) mem_has = 1'b0;
        if (a_m) begin
            if (mwe) mem_store[ma] = mw;
            mem_has = 1'b1;
            mem_delay = int'($urandom_range(max_delay));
            mem_rdata = mwe ? {$urandom, $urandom} : mem_rd(ma);
        end
        real_v = 1'b0;
        if (mem_has && mem_delay == 0) begin
            m_rsp_valid_i = 1'b1; m_rdata_i = mem_rdata; real_v = 1'b1;
        end else begin
            if (mem_has) mem_delay--;
            m_rsp_valid_i = !mem_has && pct(p_stray);
            m_rdata_i = {$urandom, $urandom};
        end
        m_req_ready_i = pct(p_mem_ready);
    endtask

    initial begin
        row_t rows [8];
        int   cyc;
        logic [63:0] g;

        rows[0] = '{1, 1, 64'h1000, 64'h2000, 64'h0,    0, 1, 64'hDEAD_BEEF, 64'hCAFE_F00D};
        rows[1] = '{1, 1, 64'h1000, 64'h2000, 64'h0,    0, 1, 64'hDEAD_BEEF, 64'hCAFE_F00D};
        rows[2] = '{1, 0, 64'h1000, 64'h0,    64'h0,    0, 0, 64'hDEAD_BEEF, 64'h0};
        rows[3] = '{0, 1, 64'h0,    64'h2008, 64'h55,   1, 1, 64'h0,         64'h0};
        rows[4] = '{1, 1, 64'h1008, 64'h2008, 64'h0,    0, 0, 64'h5A5A_0000_0000_1008, 64'h55};
        rows[5] = '{0, 1, 64'h0,    64'h2000, 64'h0,    0, 1, 64'h0,         64'hCAFE_F00D};
        rows[6] = '{1, 1, 64'h1000, 64'h1000, 64'h1234, 1, 0, 64'hDEAD_BEEF, 64'h0};
        rows[7] = '{1, 0, 64'h1000, 64'h0,    64'h0,    0, 0, 64'h1234,      64'h0};

        ref_mem[64'h1000]   = 64'hDEAD_BEEF;
        ref_mem[64'h2000]   = 64'hCAFE_F00D;
        mem_store[64'h1000] = 64'hDEAD_BEEF;
        mem_store[64'h2000] = 64'hCAFE_F00D;
        i_addr_p = '0; d_addr_p = '0; d_wdata_p = '0; d_wen_p = 1'b0;
        gen_en = 1'b0; p_mem_ready = 100; p_rsp_ready = 100; p_stray = 0; max_delay = 0;
        do_reset();

        // Directed table: grant order and returned data per row.
        for (int r = 0; r < 8; r++) begin
            i_pend = rows[r].iv; i_addr_p = rows[r].ia;
            d_pend = rows[r].dv; d_addr_p = rows[r].da;
            d_wdata_p = rows[r].dw; d_wen_p = rows[r].dwe;
            i_req_valid_i = i_pend; i_req_addr_i = i_addr_p;
            d_req_valid_i = d_pend; d_req_addr_i = d_addr_p;
            d_req_wdata_i = d_wdata_p; d_req_w_en_i = d_wen_p;
            i_rsp_ready_i = 1'b1; d_rsp_ready_i = 1'b1; m_req_ready_i = 1'b1;
            grant_log.delete(); i_rsp_log.delete(); d_rsp_log.delete();
            cyc = 0;
            while ((i_pend || d_pend || busy) && cyc < 40) begin
                step();
                cyc++;
            end
            chk("row_done", 64'(i_pend || d_pend || busy), 64'd0);
            g = (grant_log.size() > 0) ? 64'(grant_log[0]) : 64'hBAD;
            chk("first_grant", g, 64'(rows[r].exp_first_d));
            if (rows[r].iv && rows[r].dv) begin
                g = (grant_log.size() > 1) ? 64'(grant_log[1]) : 64'hBAD;
                chk("second_grant", g, 64'(!rows[r].exp_first_d));
            end
            if (rows[r].iv) begin
                g = (i_rsp_log.size() > 0) ? i_rsp_log[0] : 64'hBAD;
                chk("row_i_data", g, rows[r].exp_i);
            end
            if (rows[r].dv && !rows[r].dwe) begin
                g = (d_rsp_log.size() > 0) ? d_rsp_log[0] : 64'hBAD;
                chk("row_d_data", g, rows[r].exp_d);
            end
        end

        // Store with memory stalling three cycles.
        do_reset();
        d_req_valid_i = 1'b1; d_req_addr_i = 64'h2008; d_req_wdata_i = 64'h55;
        d_req_w_en_i = 1'b1; d_rsp_ready_i = 1'b1; m_req_ready_i = 1'b0;
        @(negedge clk);
        chk("st_d_req_ready", 64'(d_req_ready_o), 64'd1);
        @(posedge clk); #1;
        d_req_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("st_m_req_valid", 64'(m_req_valid_o), 64'd1);
            chk("st_m_addr",      m_addr_o,            64'h2008);
            chk("st_m_wdata",     m_wdata_o,           64'h55);
            chk("st_m_w_en",      64'(m_w_en_o),      64'd1);
            @(posedge clk); #1;
            if (k == 2) m_req_ready_i = 1'b1;
        end
        m_req_ready_i = 1'b0; m_rsp_valid_i = 1'b1; m_rdata_i = 64'h0;
        @(negedge clk);
        chk("st_m_req_valid_done", 64'(m_req_valid_o), 64'd0);
        chk("st_d_rsp_valid",      64'(d_rsp_valid_o), 64'd1);
        chk("st_i_rsp_valid",      64'(i_rsp_valid_o), 64'd0);
        chk("st_m_rsp_ready",      64'(m_rsp_ready_o), 64'd1);
        @(posedge clk); #1;
        m_rsp_valid_i = 1'b0;
        @(negedge clk);
        chk("st_d_rsp_valid_done", 64'(d_rsp_valid_o), 64'd0);

        // Load with the data consumer stalling while memory holds a response.
        do_reset();
        d_req_valid_i = 1'b1; d_req_addr_i = 64'h2000; d_req_w_en_i = 1'b0;
        d_rsp_ready_i = 1'b0; m_req_ready_i = 1'b1;
        @(posedge clk); #1;
        d_req_valid_i = 1'b0; i_req_valid_i = 1'b1; i_req_addr_i = 64'h1000;
        @(negedge clk);
        chk("ld_m_req_valid", 64'(m_req_valid_o), 64'd1);
        chk("ld_i_req_ready", 64'(i_req_ready_o), 64'd0);
        @(posedge clk); #1;
        m_req_ready_i = 1'b0; m_rsp_valid_i = 1'b1; m_rdata_i = 64'hCAFE_F00D;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("ld_d_rsp_valid", 64'(d_rsp_valid_o), 64'd1);
            chk("ld_d_rsp_data",  d_rsp_data_o,        64'hCAFE_F00D);
            chk("ld_m_rsp_ready", 64'(m_rsp_ready_o), 64'd0);
            chk("ld_i_req_stall", 64'(i_req_ready_o), 64'd0);
            @(posedge clk); #1;
        end
        d_rsp_ready_i = 1'b1;
        @(negedge clk);
        chk("ld_m_rsp_ready_go", 64'(m_rsp_ready_o), 64'd1);
        chk("ld_d_rsp_valid_go", 64'(d_rsp_valid_o), 64'd1);
        @(posedge clk); #1;
        m_rsp_valid_i = 1'b0; d_rsp_ready_i = 1'b0;
        @(negedge clk);
        chk("ld_i_req_ready_after", 64'(i_req_ready_o), 64'd1);
        chk("ld_d_rsp_valid_after", 64'(d_rsp_valid_o), 64'd0);
        @(posedge clk); #1;
        i_req_valid_i = 1'b0;
        @(negedge clk);
        chk("ab_m_req_valid", 64'(m_req_valid_o), 64'd1);
        chk("ab_m_addr",      m_addr_o,            64'h1000);

        // Reset while the fetch sits in REQ abandons it.
        i_req_valid_i = 1'b1; i_rsp_ready_i = 1'b1; d_rsp_ready_i = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_all_zero();
        @(posedge clk); #1;
        i_req_valid_i = 1'b0; rst_n = 1'b1;
        m_rsp_valid_i = 1'b1; m_rdata_i = 64'h1111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ab_i_rsp_valid", 64'(i_rsp_valid_o), 64'd0);
            chk("ab_d_rsp_valid", 64'(d_rsp_valid_o), 64'd0);
            chk("ab_m_rsp_ready", 64'(m_rsp_ready_o), 64'd0);
            chk("ab_m_req_idle",  64'(m_req_valid_o), 64'd0);
            @(posedge clk); #1;
            m_rsp_valid_i = 1'b0;
        end

        // Randomized traffic against the reference model.
        do_reset();
        gen_en = 1'b1; p_mem_ready = 60; p_rsp_ready = 70; p_stray = 15; max_delay = 3;
        repeat (2000) step();
        gen_en = 1'b0; p_mem_ready = 100; p_rsp_ready = 100; p_stray = 0;
        cyc = 0;
        while ((i_pend || d_pend || busy) && cyc < 200) begin
            step();
            cyc++;
        end
        chk("rand_drained", 64'(i_pend || d_pend || busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cprv_mem_arbiter.md
CPRV_MEM_ARBITER -- requirements
Module: cprv_mem_arbiter
Interface
REQ-001 Parameter DATA_WIDTH, default 64, data path width.
REQ-002 Parameter ADDR_WIDTH, default 64, address width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_req_valid_i  input  1  instruction fetch request valid.
REQ-006 i_req_ready_o  output  1  instruction request accepted.
REQ-007 i_req_addr_i  input  ADDR_WIDTH  fetch address.
REQ-008 i_rsp_valid_o  output  1  instruction response valid.
REQ-009 i_rsp_ready_i  input  1  IF stage can take response.
REQ-010 i_rsp_data_o  output  DATA_WIDTH  fetched data.
REQ-011 d_req_valid_i  input  1  data access request valid.
REQ-012 d_req_ready_o  output  1  data request accepted.
REQ-013 d_req_addr_i  input  ADDR_WIDTH  data address.
REQ-014 d_req_wdata_i  input  DATA_WIDTH  store data.
REQ-015 d_req_w_en_i  input  1  1 = store, 0 = load.
REQ-016 d_rsp_valid_o  output  1  data response valid (load data or store ack).
REQ-017 d_rsp_ready_i  input  1  MEM stage can take response.
REQ-018 d_rsp_data_o  output  DATA_WIDTH  load data; don't-care for store.
REQ-019 m_req_valid_o  output  1  request to shared memory valid.
REQ-020 m_req_ready_i  input  1  memory accepts request.
REQ-021 m_addr_o  output  ADDR_WIDTH  memory address.
REQ-022 m_wdata_o  output  DATA_WIDTH  memory write data.
REQ-023 m_w_en_o  output  1  memory write enable.
REQ-024 m_rsp_valid_i  input  1  memory response valid (every request, store included, gets one).
REQ-025 m_rsp_ready_o  output  1  arbiter takes memory response.
REQ-026 m_rdata_i  input  DATA_WIDTH  memory read data.
Function
REQ-027 All channels SHALL be valid/ready: transfer when both high on a rising edge; requesters hold valid and payload stable until ready.
REQ-028 FSM SHALL have states IDLE, REQ, RSP, with a registered owner (IMEM/DMEM) and at most one outstanding transaction.
REQ-029 IDLE: grant SHALL be computed combinationally; only the granted requester sees req_ready_o=1; on handshake latch addr, wdata, w_en (0 for IMEM), owner; next state REQ.
REQ-030 Arbitration: one valid -> grant it; both valid -> grant the requester not granted last (round-robin on last_owner, reset value IMEM so DMEM wins first tie).
REQ-031 REQ: m_req_valid_o=1 driving latched fields; stays until m_req_ready_i, then RSP; latched fields SHALL not change while m_req_valid_o=1.
REQ-032 RSP: owner rsp_valid_o = m_rsp_valid_i, owner rsp_data_o = m_rdata_i, m_rsp_ready_o = owner rsp_ready_i (combinational pass-through); non-owner rsp_valid_o=0; on handshake -> IDLE.
REQ-033 Latency: request accepted cycle N -> m_req_valid_o high cycle N+1; next request acceptable the cycle after the response handshake (one IDLE cycle minimum).
REQ-034 Outside RSP, m_rsp_ready_o and both rsp_valid_o SHALL be 0; stray m_rsp_valid_i ignored.
REQ-035 Outside IDLE both req_ready_o SHALL be 0; requests stall with no loss.
Reset
REQ-036 On rst_n low: state IDLE, last_owner IMEM, latched fields 0, every valid/ready output 0 (req_ready_o gated by reset), m_addr_o/m_wdata_o/m_w_en_o 0.
REQ-037 Reset mid-transaction SHALL abandon it; no response is delivered to either requester afterwards.
Structure
REQ-038 cprv_pkg SHALL hold arb_state_t (IDLE/REQ/RSP), owner_t (IMEM/DMEM) and default DATA_WIDTH/ADDR_WIDTH constants.
REQ-039 Sub-module cprv_rr_arb2 SHALL implement the 2-way round-robin grant (inputs two valids plus last_owner, output one-hot grant).
Verification
REQ-040 Only i_req_valid_i, addr 0x1000; memory ready immediately, returns 0xDEAD_BEEF -> m_req_valid_o cycle+1 with m_addr_o 0x1000, m_w_en_o 0, i_rsp_data_o 0xDEAD_BEEF, d_rsp_valid_o 0.
REQ-041 Both valid after reset (i 0x1000, d 0x2000) -> DMEM granted first, then IMEM; grants alternate D,I,D,I over 4 back-to-back transactions.
REQ-042 Store d 0x2008 wdata 0x55, m_req_ready_i low 3 cycles -> m_req_valid_o held 4 cycles with stable addr/wdata, m_w_en_o 1; ack drives d_rsp_valid_o.
REQ-043 d_rsp_ready_i low 2 cycles while m_rsp_valid_i high -> m_rsp_ready_o low 2 cycles, d_rsp_valid_o held, FSM stays RSP.
REQ-044 rst_n low while in REQ -> all outputs 0 at once; after release no rsp_valid_o until a new request; m_rsp_valid_i pulse in IDLE ignored.
